shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
//
// PURPOSE
//  Registered, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
//  Rotates every state row by a per-row offset, direction selected per transfer.
//  Supports 4/6/8-column state (Rijndael Nb) and byte width set by parameter.
//  Carries a 2-entry skid buffer so the round pipeline keeps running under backpressure.
//
// PARAMETERS
//  DATA_WIDTH  8  bits per state cell
//  NB          4  state columns; legal values 4, 6, 8 (anything else: $error at elaboration)
//
// PORTS
//  clk         in   1                     single clock, rising edge
//  rst_n       in   1                     asynchronous, active-low reset
//  clr         in   1                     synchronous flush of buffered data
//  in_valid    in   1                     input matrix valid
//  in_ready    out  1                     stage can accept a transfer
//  in_inverse  in   1                     0: ShiftRows (rotate left), 1: InvShiftRows (rotate right)
//  in_matrix   in   [DATA_WIDTH-1:0][0:3][0:NB-1]   state, [row][col]
//  out_valid   out  1                     output matrix valid
//  out_ready   in   1                     downstream accepts
//  out_inverse out  1                     direction used for the output matrix
//  out_matrix  out  [DATA_WIDTH-1:0][0:3][0:NB-1]   shifted state
//
// BEHAVIOUR
//  - Row offsets C[r]: r0=0, r1=1, r2=2, r3=3 for NB=4/6; r0=0, r1=1, r2=3, r3=4 for NB=8.
//  - Forward: out[r][c] = in[r][(c+C[r]) mod NB]. Inverse: out[r][c] = in[r][(c-C[r]+NB) mod NB].
//  - Shift is computed combinationally on input; the result plus direction is written into the buffer.
//  - Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
//  - Buffer: 2 entries, FIFO order. States EMPTY(0) -> ONE(1) -> FULL(2).
//    - EMPTY: input transfer -> ONE.
//    - ONE: input only -> FULL; output only -> EMPTY; both -> ONE.
//    - FULL: output -> ONE. No input accepted.
//  - in_ready = (count != 2). This is a registered decode of the state; there is no in->ready combinational path.
//  - out_valid = (count != 0). out_matrix/out_inverse come from the head entry.
//  - Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
//  - Throughput: 1 transfer/cycle sustained when out_ready stays high.
//  - While out_valid && !out_ready, out_matrix and out_inverse hold stable.
//  - Direction is captured per transfer; mixing in_inverse on back-to-back beats is legal.
//  - clr: next cycle count=0. Any input transfer in the clr cycle is discarded. clr wins over all events.
//  - Reset (asynchronous, mid-operation included): count=0, out_valid=0, in_ready=1 after release.
//    out_matrix=0 and out_inverse=0; all buffer storage is cleared to 0.
//  - Timing of in_ready after reset: in_ready=1 on the first edge after rst_n deasserts; while rst_n=0 it is 0.
//  - No data is dropped or duplicated under any valid/ready pattern.
//
// CONFIGURATION
//  SHIFT_ROWS_CNT_EN defined:
//    - adds port blk_count out [31:0].
//    - Counts output transfers and wraps 0xFFFF_FFFF -> 0.
//    - Reset to 0 by rst_n and by clr.
//  SHIFT_ROWS_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
//
// TESTING
//  1. NB=4, fwd, row1={01,02,03,04}, out_ready=1 -> next cycle out row1={02,03,04,01}, out_valid=1.
//  2. NB=4, inv, row3={A0,A1,A2,A3} -> row3={A1,A2,A3,A0}; row0 unchanged; out_inverse=1.
//  3. NB=8, fwd, row2=00..07 -> {03,04,05,06,07,00,01,02}; row3 -> {04,05,06,07,00,01,02,03}.
//  4. Backpressure with out_ready=0, 3 beats offered:
//     - in_ready=0 after 2 accepted; the 3rd beat is held.
//     - out_ready=1 -> beats exit in order 1,2,3 with no gaps.
//  5. Flush: buffer FULL, assert clr and in_valid together -> out_valid=0 next cycle, nothing emitted.
//     Repeat with rst_n pulsed low mid-stream -> out_valid=0 and out_matrix=0 immediately.
//  6. SHIFT_ROWS_CNT_EN: 5 output transfers -> blk_count=5.
//     Force the counter to FFFF_FFFF, one more transfer -> blk_count=0.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage with a 2-entry skid buffer.
// Optional output-transfer counter port blk_count enabled by `define SHIFT_ROWS_CNT_EN.
module shift_rows_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NB         = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clr,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_inverse,
    input  logic [0:3][0:NB-1][DATA_WIDTH-1:0]     in_matrix,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_inverse,
    output logic [0:3][0:NB-1][DATA_WIDTH-1:0]     out_matrix
`ifdef SHIFT_ROWS_CNT_EN
    ,
    output logic [31:0]                            blk_count
`endif
);

    // state | meaning
    // EMPTY | no entries held, out_valid low
    // ONE   | head holds one entry
    // FULL  | head and tail both hold entries, input stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef logic [0:3][0:NB-1][DATA_WIDTH-1:0] matrix_t;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // Rijndael row offsets; only the wide 8-column state spreads rows 2 and 3 further.
    function automatic int row_off(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return (NB == 8) ? 3 : 2;
        return (NB == 8) ? 4 : 3;
    endfunction

    state_t  state;
    matrix_t shifted;
    matrix_t head_q;
    matrix_t tail_q;
    logic    head_inv_q;
    logic    tail_inv_q;
    logic    in_ready_q;
    logic    out_valid_q;
    logic    in_fire;
    logic    out_fire;

    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < NB; c++) begin : g_col
                localparam int SRC_FWD = (c + row_off(r)) % NB;
                localparam int SRC_INV = (c - row_off(r) + NB) % NB;
                assign shifted[r][c] = in_inverse ? in_matrix[r][SRC_INV]
                                                  : in_matrix[r][SRC_FWD];
            end
        end
    endgenerate

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // in_ready/out_valid are registered decodes of the next state, so no
    // combinational path exists from any input to the handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            head_inv_q  <= 1'b0;
            tail_inv_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head_q      <= shifted;
                        head_inv_q  <= in_inverse;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        tail_q     <= shifted;
                        tail_inv_q <= in_inverse;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (!in_fire && out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end else if (in_fire && out_fire) begin
                        head_q     <= shifted;
                        head_inv_q <= in_inverse;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head_q     <= tail_q;
                        head_inv_q <= tail_inv_q;
                        state      <= ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_matrix  = head_q;
    assign out_inverse = head_inv_q;

`ifdef SHIFT_ROWS_CNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= 32'd0;
        end else if (clr) begin
            blk_count_q <= 32'd0;
        end else if (out_fire) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 and NB=8 instances side by side.
module tb_shift_rows_pipe;

    typedef logic [0:3][0:3][7:0] m4_t;
    typedef logic [0:3][0:7][7:0] m8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;

    logic in_valid = 1'b0, in_inverse = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_inverse;
    m4_t  in_matrix = '0;
    m4_t  out_matrix;

    logic in8_valid = 1'b0, in8_inverse = 1'b0, out8_ready = 1'b0;
    logic in8_ready, out8_valid, out8_inverse;
    m8_t  in8_matrix = '0;
    m8_t  out8_matrix;

`ifdef SHIFT_ROWS_CNT_EN
    logic [31:0] blk_count, blk8_count;
    int cnt_model = 0;
`endif

    int   checks = 0;
    int   errors = 0;
    int   out_fires = 0;
    bit   last_in_fire = 0;
    logic [128:0] q4[$];
    logic [256:0] q8[$];

    always #5 clk = ~clk;

    shift_rows_pipe #(.DATA_WIDTH(8), .NB(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
        .in_matrix(in_matrix), .out_valid(out_valid), .out_ready(out_ready),
        .out_inverse(out_inverse), .out_matrix(out_matrix)
`ifdef SHIFT_ROWS_CNT_EN
        , .blk_count(blk_count)
`endif
    );

    shift_rows_pipe #(.DATA_WIDTH(8), .NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_inverse(in8_inverse),
        .in_matrix(in8_matrix), .out_valid(out8_valid), .out_ready(out8_ready),
        .out_inverse(out8_inverse), .out_matrix(out8_matrix)
`ifdef SHIFT_ROWS_CNT_EN
        , .blk_count(blk8_count)
`endif
    );

    // Reference: rotate each row one step at a time, offset-many times.
    function automatic m4_t model4(input m4_t m, input logic inv);
        m4_t r;
        logic [7:0] t;
        r = m;
        for (int row = 0; row < 4; row++) begin
            for (int k = 0; k < row; k++) begin
                if (!inv) begin
                    t = r[row][0];
                    for (int c = 0; c < 3; c++) r[row][c] = r[row][c+1];
                    r[row][3] = t;
                end else begin
                    t = r[row][3];
                    for (int c = 3; c > 0; c--) r[row][c] = r[row][c-1];
                    r[row][0] = t;
                end
            end
        end
        return r;
    endfunction

    function automatic m8_t model8(input m8_t m, input logic inv);
        m8_t r;
        logic [7:0] t;
        int off[4];
        off = '{0, 1, 3, 4};
        r = m;
        for (int row = 0; row < 4; row++) begin
            for (int k = 0; k < off[row]; k++) begin
                if (!inv) begin
                    t = r[row][0];
                    for (int c = 0; c < 7; c++) r[row][c] = r[row][c+1];
                    r[row][7] = t;
                end else begin
                    t = r[row][7];
                    for (int c = 7; c > 0; c--) r[row][c] = r[row][c-1];
                    r[row][0] = t;
                end
            end
        end
        return r;
    endfunction

    function automatic m4_t rand4();
        m4_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = 8'($urandom);
        return r;
    endfunction

    function automatic m8_t rand8();
        m8_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) r[i][j] = 8'($urandom);
        return r;
    endfunction

    // Sample at the falling edge, score transfers, then return just after the rising edge.
    task automatic tick();
        logic [128:0] e4;
        logic [256:0] e8;
        @(negedge clk);
        last_in_fire = 0;
        if (clr) begin
            q4.delete();
            q8.delete();
`ifdef SHIFT_ROWS_CNT_EN
            cnt_model = 0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_fires++;
`ifdef SHIFT_ROWS_CNT_EN
                cnt_model++;
`endif
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL sb4_extra: output %h with nothing expected", out_matrix);
                end else begin
                    e4 = q4.pop_front();
                    if ({out_inverse, out_matrix} !== e4) begin
                        errors++;
                        $display("FAIL sb4_data: got %h expected %h", {out_inverse, out_matrix}, e4);
                    end
                end
            end
            if (out8_valid && out8_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL sb8_extra: output %h with nothing expected", out8_matrix);
                end else begin
                    e8 = q8.pop_front();
                    if ({out8_inverse, out8_matrix} !== e8) begin
                        errors++;
                        $display("FAIL sb8_data: got %h expected %h", {out8_inverse, out8_matrix}, e8);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q4.push_back({in_inverse, model4(in_matrix, in_inverse)});
                last_in_fire = 1;
            end
            if (in8_valid && in8_ready)
                q8.push_back({in8_inverse, model8(in8_matrix, in8_inverse)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || out8_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b/%b expected 0/0", out_valid, out8_valid);
        end
        checks++;
        if (out_matrix !== '0 || out_inverse !== 1'b0) begin
            errors++; $display("FAIL rst_out_data: got %h/%b expected 0/0", out_matrix, out_inverse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || in8_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready_high: got %b/%b expected 1/1", in_ready, in8_ready);
        end
    endtask

    task automatic test_forward();
        m4_t m;
        logic [0:3][7:0] exp_row;
        m = rand4();
        m[1] = {8'h01, 8'h02, 8'h03, 8'h04};
        out_ready = 1'b1;
        in_matrix = m;
        in_inverse = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_row = {8'h02, 8'h03, 8'h04, 8'h01};
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_latency: out_valid %b expected 1", out_valid); end
        checks++;
        if (out_matrix[1] !== exp_row || out_inverse !== 1'b0) begin
            errors++; $display("FAIL fwd_row1: got %h/%b expected %h/0", out_matrix[1], out_inverse, exp_row);
        end
        tick();
    endtask

    task automatic test_inverse();
        m4_t m;
        logic [0:3][7:0] exp_row;
        m = rand4();
        m[3] = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        out_ready = 1'b1;
        in_matrix = m;
        in_inverse = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_row = {8'hA1, 8'hA2, 8'hA3, 8'hA0};
        checks++;
        if (out_matrix[3] !== exp_row) begin
            errors++; $display("FAIL inv_row3: got %h expected %h", out_matrix[3], exp_row);
        end
        checks++;
        if (out_matrix[0] !== m[0] || out_inverse !== 1'b1) begin
            errors++; $display("FAIL inv_row0: got %h/%b expected %h/1", out_matrix[0], out_inverse, m[0]);
        end
        tick();
    endtask

    task automatic test_nb8();
        m8_t m;
        logic [0:7][7:0] seq, exp2, exp3;
        seq  = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        exp2 = {8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01, 8'h02};
        exp3 = {8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        m = rand8();
        m[2] = seq;
        m[3] = seq;
        out8_ready = 1'b1;
        in8_matrix = m;
        in8_inverse = 1'b0;
        in8_valid = 1'b1;
        tick();
        in8_matrix = rand8();
        in8_inverse = 1'b1;
        checks++;
        if (out8_matrix[2] !== exp2 || out8_matrix[3] !== exp3) begin
            errors++; $display("FAIL nb8_rows: got %h %h expected %h %h", out8_matrix[2], out8_matrix[3], exp2, exp3);
        end
        tick();
        in8_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int start, accepted;
        start = out_fires;
        accepted = 0;
        out_ready = 1'b1;
        out8_ready = 1'b1;
        in_valid = 1'b1;
        in8_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_matrix = rand4();
            in_inverse = i[0];
            in8_matrix = rand8();
            in8_inverse = ~i[0];
            tick();
            if (last_in_fire) accepted++;
        end
        in_valid = 1'b0;
        in8_valid = 1'b0;
        tick();
        checks++;
        if (accepted != 8) begin errors++; $display("FAIL b2b_accept: got %0d expected 8", accepted); end
        checks++;
        if (out_fires - start != 8) begin errors++; $display("FAIL b2b_throughput: got %0d expected 8", out_fires - start); end
    endtask

    task automatic test_backpressure();
        m4_t b1, b2, b3;
        int start;
        b1 = rand4(); b2 = rand4(); b3 = rand4();
        start = out_fires;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_matrix = b1; in_inverse = 1'b0;
        tick();
        in_matrix = b2; in_inverse = 1'b1;
        tick();
        in_matrix = b3; in_inverse = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_matrix !== model4(b1, 1'b0) || out_inverse !== 1'b0) begin
            errors++; $display("FAIL bp_hold: got %b %h expected 1 %h", out_valid, out_matrix, model4(b1, 1'b0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (last_in_fire) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (out_fires - start != 3 || q4.size() != 0) begin
            errors++; $display("FAIL bp_drain: got %0d out, %0d left expected 3, 0", out_fires - start, q4.size());
        end
    endtask

    task automatic test_flush();
        int start;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_matrix = rand4(); in_inverse = 1'b0;
        tick();
        in_matrix = rand4();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clr_one: got valid %b ready %b expected 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_matrix = rand4();
        tick();
        in_matrix = rand4();
        tick();
        in_matrix = rand4();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_full: out_valid %b expected 0", out_valid); end
        start = out_fires;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_fires != start) begin errors++; $display("FAIL clr_emit: got %0d outputs expected 0", out_fires - start); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_matrix = rand4(); in_inverse = 1'b1;
        tick();
        in_matrix = rand4();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q4.delete();
        q8.delete();
`ifdef SHIFT_ROWS_CNT_EN
        cnt_model = 0;
`endif
        checks++;
        if (out_valid !== 1'b0 || out_matrix !== '0 || out_inverse !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got v%b r%b i%b %h expected v0 r0 i0 0", out_valid, in_ready, out_inverse, out_matrix);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: got r%b v%b expected r1 v0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 120; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_inverse  = 1'($urandom_range(0, 1));
            in_matrix   = rand4();
            out_ready   = 1'($urandom_range(0, 3) != 0);
            in8_valid   = 1'($urandom_range(0, 1));
            in8_inverse = 1'($urandom_range(0, 1));
            in8_matrix  = rand8();
            out8_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        in8_valid = 1'b0;
        out_ready = 1'b1;
        out8_ready = 1'b1;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (q4.size() != 0 || q8.size() != 0 || out_valid !== 1'b0 || out8_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain: left %0d/%0d valid %b/%b expected 0/0 0/0", q4.size(), q8.size(), out_valid, out8_valid);
        end
    endtask

`ifdef SHIFT_ROWS_CNT_EN
    task automatic test_counter();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_matrix = rand4();
            in_inverse = i[0];
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (blk_count !== 32'd5 || blk_count !== 32'(cnt_model)) begin
            errors++; $display("FAIL cnt_five: got %0d expected 5", blk_count);
        end
        force dut.blk_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.blk_count_q;
        in_valid = 1'b1;
        in_matrix = rand4();
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (blk_count !== 32'd0) begin errors++; $display("FAIL cnt_wrap: got %h expected 0", blk_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_nb8();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
`ifdef SHIFT_ROWS_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
